dti_apb_req_arbiter: RTL and testbench

Round-robin APB master arbiter that shares one APB3/APB4 completer port between NUM_REQ internal requesters. Each requester issues single transfers over a valid/ready command channel. The arbiter grants one requester at a time, sequences the APB SETUP/ACCESS phases, and returns read data and error status to the granted requester. It sits between the UART-side/test-side bus users and the APB slave.

---
 rtl/dti_apb_req_arbiter_if.sv | 35 +++
 rtl/dti_apb_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dti_apb_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dti_apb_req_arbiter_if.sv
// ============================================================================
// Module   : dti_apb_req_arbiter_if
// Brief    : APB3/APB4 completer-port bundle shared by the request arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dti_apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

`default_nettype wire

// File: rtl/dti_apb_req_arbiter.sv
// ============================================================================
// Module   : dti_apb_req_arbiter
// Brief    : Round-robin arbiter sharing one APB completer among NUM_REQ users.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dti_apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  wire logic                           PCLK,
  input  wire logic                           PRESETn,
  input  wire logic [NUM_REQ-1:0]             req_valid,
  output logic      [NUM_REQ-1:0]             req_ready,
  input  wire logic [NUM_REQ-1:0]             req_write,
  input  wire logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  wire logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  wire logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
  output logic      [NUM_REQ-1:0]             rsp_valid,
  output logic      [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                                rsp_slverr,
  output logic      [$clog2(NUM_REQ)-1:0]     grant_id,
  dti_apb_req_arbiter_if.master               apb
);

  localparam int c_IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [c_IDW-1:0]      r_ptr;
  logic [c_IDW-1:0]      r_grant;
  logic [c_IDW-1:0]      w_win_id;
  logic                  w_accept;
  logic                  w_complete;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;

  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_slverr;

  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];
  logic [STRB_WIDTH-1:0] w_strb_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_strb_arr[gi]  = req_strb[gi*STRB_WIDTH +: STRB_WIDTH];
    end
  endgenerate

  // (base + step) mod NUM_REQ without a divider; step never exceeds NUM_REQ.
  function automatic logic [c_IDW-1:0] rr_index(input logic [c_IDW-1:0] base,
                                                input int               step);
    logic [c_IDW:0] sum;
    sum = {1'b0, base} + (c_IDW+1)'(step);
    if (sum >= (c_IDW+1)'(NUM_REQ)) begin
      sum = sum - (c_IDW+1)'(NUM_REQ);
    end
    return sum[c_IDW-1:0];
  endfunction

  // Scan from farthest to nearest so the nearest valid after the pointer wins.
  always_comb begin
    w_win_id = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[rr_index(r_ptr, k)]) begin
        w_win_id = rr_index(r_ptr, k);
      end
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && (|req_valid);
  assign w_complete = (r_state == ST_ACCESS) && apb.PREADY;

  // Gated by reset so no requester sees an accept while the block is held.
  always_comb begin
    req_ready = '0;
    if (w_accept && PRESETn) begin
      req_ready[w_win_id] = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (apb.PREADY) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ptr   <= c_IDW'(NUM_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_win_id;
      r_grant <= w_win_id;
      r_addr  <= w_addr_arr[w_win_id];
      r_write <= req_write[w_win_id];
      r_wdata <= req_write[w_win_id] ? w_wdata_arr[w_win_id] : '0;
      r_strb  <= req_write[w_win_id] ? w_strb_arr[w_win_id]  : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      if (w_complete) begin
        r_rsp_valid[r_grant] <= 1'b1;
        r_rsp_rdata          <= r_write ? '0 : apb.PRDATA;
        r_rsp_slverr         <= apb.PSLVERR;
      end
    end
  end

  assign apb.PSEL    = (r_state != ST_IDLE);
  assign apb.PENABLE = (r_state == ST_ACCESS);
  assign apb.PWRITE  = r_write;
  assign apb.PADDR   = r_addr;
  assign apb.PWDATA  = r_wdata;
  assign apb.PSTRB   = r_strb;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;
  assign grant_id   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_dti_apb_req_arbiter.sv
// ============================================================================
// Module   : tb_dti_apb_req_arbiter
// Brief    : Randomized self-checking bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dti_apb_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = 4;
  localparam int IDW     = 2;

  logic                  PCLK    = 1'b0;
  logic                  PRESETn = 1'b1;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ*SW-1:0] req_strb;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_slverr;
  logic [IDW-1:0]        grant_id;

  dti_apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) apb ();

  dti_apb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .grant_id(grant_id), .apb(apb)
  );

  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus / slave controls (written by the main process only).
  bit          hold_all  = 1'b0;
  bit          rand_mode = 1'b0;
  bit          slv_rand  = 1'b0;
  int          wait_cfg  = 0;
  logic [31:0] rdata_cfg = 32'h1234_5678;
  bit          err_cfg   = 1'b0;

  // Observations and model state (written by the monitor only).
  logic [NUM_REQ-1:0] acc_mask = '0;
  int                 acc_id_q[$];
  int                 acc_cyc_q[$];
  int                 rsp_tot;
  int                 t_id;
  logic [AW-1:0]      t_addr;
  logic               t_write;
  logic [DW-1:0]      t_wdata;
  logic [SW-1:0]      t_strb;

  // Round-robin rule: first valid requester after the last grant, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic check_bus();
    check_eq("paddr",  apb.PADDR,  t_addr);
    check_eq("pwrite", apb.PWRITE, t_write);
    check_eq("pwdata", apb.PWDATA, t_write ? t_wdata : '0);
    check_eq("pstrb",  apb.PSTRB,  t_write ? t_strb  : '0);
  endtask

  // APB completer: programmable or random wait states, data and error.
  initial begin
    int wcnt;
    int wait_cur;
    wcnt = 0;
    wait_cur = 0;
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESETn || !apb.PSEL) begin
        apb.PREADY = 1'b0; wcnt = 0;
      end else if (!apb.PENABLE) begin
        wcnt = 0;
        wait_cur = slv_rand ? int'($urandom_range(0, 3)) : wait_cfg;
        apb.PREADY = 1'b0;
      end else if (wcnt < wait_cur) begin
        apb.PREADY = 1'b0; wcnt++;
      end else begin
        apb.PREADY = 1'b1;
      end
      apb.PRDATA  = slv_rand ? $urandom : rdata_cfg;
      apb.PSLVERR = apb.PREADY && (slv_rand ? ($urandom_range(0, 3) == 0) : err_cfg);
    end
  end

  // Transaction-level reference: phase 0 free, 1 setup, 2 access.
  initial begin
    int phase, mptr, cyc, w, rsp_id;
    bit rsp_pend, have_rsp, have_bus;
    logic [DW-1:0] e_rdata;
    logic e_err;
    logic [NUM_REQ-1:0] exp_oh;
    phase = 0; mptr = NUM_REQ - 1; cyc = 0; rsp_id = 0; w = -1;
    rsp_pend = 0; have_rsp = 0; have_bus = 0; e_rdata = '0; e_err = 0; rsp_tot = 0;
    forever begin
      @(negedge PCLK);
      acc_mask = req_valid & req_ready;
      if (!PRESETn) begin
        phase = 0; mptr = NUM_REQ - 1; cyc = 0; rsp_tot = 0;
        rsp_pend = 0; have_rsp = 0; have_bus = 0;
        acc_id_q.delete(); acc_cyc_q.delete();
      end else begin
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (acc_mask[i]) begin
            acc_id_q.push_back(i); acc_cyc_q.push_back(cyc);
          end
        end
        if (rsp_valid != '0) rsp_tot++;
        exp_oh = '0;
        if (rsp_pend) exp_oh[rsp_id] = 1'b1;
        check_eq("rsp_valid", rsp_valid, exp_oh);
        if (rsp_pend) begin have_rsp = 1; rsp_pend = 0; end
        if (have_rsp) begin
          check_eq("rsp_rdata", rsp_rdata, e_rdata);
          check_eq("rsp_slverr", rsp_slverr, e_err);
        end
        case (phase)
          0: begin
            w = rr_pick(req_valid, mptr);
            exp_oh = '0;
            if (w >= 0) exp_oh[w] = 1'b1;
            check_eq("req_ready", req_ready, exp_oh);
            check_eq("idle_psel_penable", {apb.PSEL, apb.PENABLE}, 2'b00);
            if (have_bus) check_bus();
            if (w >= 0) begin
              t_id    = w;
              t_write = req_write[w];
              t_addr  = req_addr[w*AW +: AW];
              t_wdata = req_wdata[w*DW +: DW];
              t_strb  = req_strb[w*SW +: SW];
              mptr = w; phase = 1; have_bus = 1;
            end
          end
          1: begin
            check_eq("setup_psel_penable", {apb.PSEL, apb.PENABLE}, 2'b10);
            check_eq("setup_ready", req_ready, '0);
            check_eq("grant_id", grant_id, t_id);
            check_bus();
            phase = 2;
          end
          default: begin
            check_eq("access_psel_penable", {apb.PSEL, apb.PENABLE}, 2'b11);
            check_eq("access_ready", req_ready, '0);
            check_bus();
            if (apb.PREADY) begin
              e_rdata = t_write ? '0 : apb.PRDATA;
              e_err   = apb.PSLVERR;
              rsp_pend = 1; rsp_id = t_id; phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic set_payload(input int i, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i]         = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW]  = s;
  endtask

  task automatic set_random(input int i);
    set_payload(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom_range(0, 15)));
  endtask

  // One clock of requester behaviour; lands 2 ns after the rising edge.
  task automatic step();
    @(posedge PCLK); #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_mask[i]) begin
        if (hold_all) set_random(i);
        else req_valid[i] = 1'b0;
      end
      if (rand_mode && !req_valid[i] && $urandom_range(0, 2) == 0) begin
        set_random(i);
        req_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic run_one(input int id, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input int waits,
                         input logic [DW-1:0] rd, input bit err, input int exp_lat,
                         input logic [DW-1:0] exp_rd, input bit exp_err);
    int lat;
    logic [NUM_REQ-1:0] owner;
    lat = 0;
    wait_cfg = waits; rdata_cfg = rd; err_cfg = err;
    set_payload(id, wr, a, d, s);
    req_valid[id] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (rsp_valid != '0) begin lat = k; break; end
    end
    owner = '0;
    owner[id] = 1'b1;
    check_eq("latency", lat, exp_lat);
    check_eq("rsp_owner", rsp_valid, owner);
    check_eq("rsp_rdata_dir", rsp_rdata, exp_rd);
    check_eq("rsp_slverr_dir", rsp_slverr, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit reached;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    #1 PRESETn = 1'b0;
    #1;
    check_eq("rst_psel", apb.PSEL, 1'b0);
    check_eq("rst_penable", apb.PENABLE, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, '0);
    check_eq("rst_grant_id", grant_id, '0);
    check_eq("rst_pstrb", apb.PSTRB, '0);
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b1;

    run_one(1, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 32'h1234_5678, 1'b0, 3, 32'h0, 1'b0);
    run_one(2, 1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF, 2, 32'h0000_0041, 1'b0, 5, 32'h41, 1'b0);

    // Abort a transfer mid-ACCESS, then prove rotation restarts at requester 0.
    wait_cfg = 20;
    set_payload(0, 1'b1, 32'h80, 32'h1111_2222, 4'h3);
    req_valid[0] = 1'b1;
    reached = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (apb.PENABLE) begin reached = 1; break; end
    end
    check_eq("reach_access", reached, 1'b1);
    #1;
    for (int i = 0; i < NUM_REQ; i++) set_random(i);
    req_valid = '1;
    hold_all = 1'b1;
    wait_cfg = 0;
    PRESETn = 1'b0;
    #1;
    check_eq("abort_psel", apb.PSEL, 1'b0);
    check_eq("abort_penable", apb.PENABLE, 1'b0);
    check_eq("abort_req_ready", req_ready, '0);
    check_eq("abort_rsp_valid", rsp_valid, '0);
    check_eq("abort_pstrb", apb.PSTRB, '0);
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    for (int k = 0; k < 40 && acc_id_q.size() < 8; k++) step();
    check_eq("rr_count", acc_id_q.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < acc_id_q.size(); k++) begin
      check_eq("rr_id", acc_id_q[k], k % NUM_REQ);
      if (k > 0) check_eq("rr_gap", acc_cyc_q[k] - acc_cyc_q[k-1], 3);
    end
    hold_all = 1'b0;
    req_valid = '0;
    repeat (8) step();

    run_one(3, 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b1, 3, 32'hDEAD_BEEF, 1'b1);
    run_one(0, 1'b0, 32'h24, 32'h0, 4'h0, 1, 32'h0000_00AA, 1'b0, 4, 32'hAA, 1'b0);

    rand_mode = 1'b1;
    slv_rand  = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    repeat (40) step();
    check_eq("drain_idle", apb.PSEL, 1'b0);
    check_eq("rsp_total", rsp_tot, acc_id_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
